hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage core. It drives the stall, flush and forwarding controls that the inter-stage pipeline registers and execute-stage operand muxes consume; its `FlushE_o` is the `clr_i` of the decode-to-execute register. It resolves three kinds of hazard: load-use, taken branch/jump and multi-cycle data-memory access. It also keeps a watchdog FSM for memory waits and saturating stall/flush performance counters.

## Interface
- `REGISTER_ADDRESS_WIDTH`, default 5: register index width.
- `COUNT_WIDTH`, default 32: performance counter width.
- `MEM_TIMEOUT`, default 16: number of wait cycles before `MemErr_o` is raised.

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: reset. **Asynchronous and active-low.**
- `Rs1D_i`, `Rs2D_i` in `REGISTER_ADDRESS_WIDTH`: decode-stage source registers.
- `Rs1E_i`, `Rs2E_i`, `RdE_i` in `REGISTER_ADDRESS_WIDTH`: execute-stage source and destination registers.
- `ResultSrcE_i` in 2: execute-stage result select. `2'b01` means load.
- `PCSrcE_i` in 1: branch taken or jump, resolved in execute.
- `RdM_i` in `REGISTER_ADDRESS_WIDTH`, `RegWriteM_i` in 1: memory-stage writeback info.
- `RdW_i` in `REGISTER_ADDRESS_WIDTH`, `RegWriteW_i` in 1: writeback-stage info.
- `MemReqM_i` in 1: a load or store is in the memory stage.
- `MemReadyM_i` in 1: data memory completes the access this cycle.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o` out 1: hold the PC and the D/E/M pipeline registers.
- `FlushD_o`, `FlushE_o`, `FlushW_o` out 1: bubble the D, E and W registers.
- `ForwardAE_o`, `ForwardBE_o` out 2: operand source select. `00` = register file, `01` = W result, `10` = M ALU result.
- `MemErr_o` out 1: sticky memory-timeout flag.
- `StallCount_o`, `FlushCount_o` out `COUNT_WIDTH`: performance counters.

## Operation
**Forwarding (combinational)**
- `ForwardAE_o = 10` if `RegWriteM_i` and `RdM_i == Rs1E_i` and `Rs1E_i != 0`.
- Otherwise `01` if `RegWriteW_i` and `RdW_i == Rs1E_i` and `Rs1E_i != 0`.
- Otherwise `00`.
- M takes priority over W. `ForwardBE_o` follows the same rules using `Rs2E_i`.

**Hazard terms**
- `lwStall = (ResultSrcE_i == 01) && RdE_i != 0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i)`.
- `memStall = MemReqM_i && !MemReadyM_i`.

**Output priority: `memStall` dominates**
- `StallE_o = StallM_o = FlushW_o = memStall`.
- `StallF_o = StallD_o = memStall | lwStall`.
- `FlushD_o = PCSrcE_i & !memStall`.
- `FlushE_o = (lwStall | PCSrcE_i) & !memStall`.
- During `memStall` the E stage is frozen, so `PCSrcE_i` persists and its flush is applied on the first cycle after the stall. A branch is never lost.

**Watchdog FSM: states `IDLE`, `MEM_WAIT`**
- `IDLE`: if `memStall`, go to `MEM_WAIT` and set `waitCnt = 1`.
- `MEM_WAIT`:
  - If `!memStall`, go to `IDLE` and clear `waitCnt`.
  - Else increment `waitCnt`, saturating at `MEM_TIMEOUT`.
  - When `waitCnt == MEM_TIMEOUT` and `memStall` is still high, set `MemErr_o`.
- `MemErr_o` stays set until reset.
- Stalls continue regardless of `MemErr_o`. The flag is reporting only.

**Counters**
- `StallCount_o` increments on every cycle with `StallF_o == 1`.
- `FlushCount_o` increments on every cycle with `FlushE_o == 1`.
- Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the current-cycle inputs, with zero latency. They are valid before the next `clk_i` rising edge.
- FSM, `waitCnt`, `MemErr_o` and both counters update on the `clk_i` rising edge.
- Counter values reflect events up to and including the previous cycle.
- Asynchronous reset (`rst_ni` low) immediately sets:
  - state = `IDLE`, `waitCnt` = 0
  - `MemErr_o` = 0, `StallCount_o` = 0, `FlushCount_o` = 0
- Combinational outputs follow their inputs during reset.
- Reset deasserted mid-wait: the FSM restarts in `IDLE`. If `memStall` is still high, it re-enters `MEM_WAIT` on the next edge with the count restarting at 1.
- `lwStall` and `PCSrcE_i` in the same cycle: `FlushD_o = 1`, `FlushE_o = 1`, `StallF_o = StallD_o = 1`. The PC mux selects the branch target because the branch resolves in E.
- `MemReadyM_i` high on the same cycle as `MemReqM_i`: no stall, and the FSM stays in `IDLE`.

## Structure
- Shared package `hazard_pkg` holds:
  - the `state_t` enum (`IDLE`, `MEM_WAIT`);
  - the `fwd_sel_t` encodings (`FWD_RF`, `FWD_W`, `FWD_M`);
  - the `RESULT_SRC_LOAD = 2'b01` constant, which the control unit also uses.
- One sub-module, `sat_counter`, parameterised by width and with an enable input. It is instantiated twice, for the stall and flush counters.

## Test plan
- **M forward:** `RegWriteM_i = 1`, `RdM_i = 5`, `Rs1E_i = 5`, `RdW_i = 5`, `RegWriteW_i = 1` -> `ForwardAE_o = 10`. Set `Rs1E_i = 0` -> `00`.
- **Load-use:** `ResultSrcE_i = 01`, `RdE_i = 3`, `Rs2D_i = 3` -> `StallF_o = StallD_o = FlushE_o = 1`, `FlushD_o = 0`. `StallCount_o` reads +1 on the next cycle.
- **Taken branch:** `PCSrcE_i = 1` -> `FlushD_o = FlushE_o = 1`, no stalls. `FlushCount_o` reads +1 after the edge.
- **Memory wait, 3 cycles:** `MemReqM_i = 1`, `MemReadyM_i = 0` for 3 cycles with `PCSrcE_i = 1` -> all stalls and `FlushW_o` high, flushes low. On the ready cycle, flushes assert and the FSM returns to `IDLE`.
- **Timeout:** `MEM_TIMEOUT = 4`, memory not ready for 6 cycles -> `MemErr_o` rises after the 4th edge and stays high after ready. `rst_ni` low clears it asynchronously.
- **Saturation:** `COUNT_WIDTH = 3`, hold `lwStall` for 10 cycles -> `StallCount_o` stops at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : watchdog state encoding, operand-forwarding select encodings and
//           the load result-select constant shared with the control unit.
// Ports   : none (package).

package hazard_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // The memory-stage value is younger than the writeback value, so it wins.
   function automatic fwd_sel_t fwd_select(input logic m_hit, input logic w_hit);
      if (m_hit)
         return FWD_M;
      else if (w_hit)
         return FWD_W;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-gated up counter that sticks at all-ones
//
// Purpose : performance event counter that never wraps.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset, clears the count
//           en     - count this cycle
//           count  - current value (events up to the previous edge)

module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en && (count != {WIDTH{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall, flush and forwarding control for the five-stage core
//
// Purpose : resolves load-use, taken branch/jump and multi-cycle data-memory
//           hazards; keeps a memory-wait watchdog and stall/flush counters.
// Ports   : clk_i, rst_ni                  - clock, asynchronous active-low reset
//           Rs1D_i, Rs2D_i                 - decode-stage source registers
//           Rs1E_i, Rs2E_i, RdE_i          - execute-stage sources / destination
//           ResultSrcE_i                   - execute result select (01 = load)
//           PCSrcE_i                       - branch taken / jump resolved in E
//           RdM_i, RegWriteM_i             - memory-stage writeback info
//           RdW_i, RegWriteW_i             - writeback-stage info
//           MemReqM_i, MemReadyM_i         - data memory request / completion
//           StallF_o..StallM_o             - hold PC and D/E/M registers
//           FlushD_o, FlushE_o, FlushW_o   - bubble D, E and W registers
//           ForwardAE_o, ForwardBE_o       - execute operand source selects
//           MemErr_o                       - sticky memory-timeout flag
//           StallCount_o, FlushCount_o     - saturating performance counters

module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int COUNT_WIDTH            = 32,
   parameter int MEM_TIMEOUT            = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
   input  logic [1:0]                        ResultSrcE_i,
   input  logic                              PCSrcE_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
   input  logic                              RegWriteM_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
   input  logic                              RegWriteW_i,
   input  logic                              MemReqM_i,
   input  logic                              MemReadyM_i,
   output logic                              StallF_o,
   output logic                              StallD_o,
   output logic                              StallE_o,
   output logic                              StallM_o,
   output logic                              FlushD_o,
   output logic                              FlushE_o,
   output logic                              FlushW_o,
   output logic [1:0]                        ForwardAE_o,
   output logic [1:0]                        ForwardBE_o,
   output logic                              MemErr_o,
   output logic [COUNT_WIDTH-1:0]            StallCount_o,
   output logic [COUNT_WIDTH-1:0]            FlushCount_o
);

   localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   logic              lw_stall;
   logic              mem_stall;
   logic              m_hit_a, w_hit_a, m_hit_b, w_hit_b;
   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_next;

   // ---------------- forwarding ----------------
   always_comb begin
      m_hit_a = RegWriteM_i && (RdM_i == Rs1E_i) && (Rs1E_i != '0);
      w_hit_a = RegWriteW_i && (RdW_i == Rs1E_i) && (Rs1E_i != '0);
      m_hit_b = RegWriteM_i && (RdM_i == Rs2E_i) && (Rs2E_i != '0);
      w_hit_b = RegWriteW_i && (RdW_i == Rs2E_i) && (Rs2E_i != '0);
      ForwardAE_o = fwd_select(m_hit_a, w_hit_a);
      ForwardBE_o = fwd_select(m_hit_b, w_hit_b);
   end

   // ---------------- stall / flush ----------------
   always_comb begin
      lw_stall  = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                  ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
      mem_stall = MemReqM_i && !MemReadyM_i;

      // A memory wait freezes E, so any pending branch flush is deferred until
      // the wait ends; PCSrcE_i is still presented then because E is held.
      StallE_o = mem_stall;
      StallM_o = mem_stall;
      FlushW_o = mem_stall;
      StallF_o = mem_stall | lw_stall;
      StallD_o = mem_stall | lw_stall;
      FlushD_o = PCSrcE_i & ~mem_stall;
      FlushE_o = (lw_stall | PCSrcE_i) & ~mem_stall;
   end

   // ---------------- memory-wait watchdog ----------------
   always_comb begin
      wait_next = '0;
      if (mem_stall) begin
         if (state == IDLE)
            wait_next = WAIT_ONE;
         else if (wait_cnt == WAIT_MAX)
            wait_next = WAIT_MAX;
         else
            wait_next = wait_cnt + 1'b1;
      end
   end

   // The error is raised on the same edge the wait count reaches the limit,
   // so it is visible right after the MEM_TIMEOUT-th stalled edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         wait_cnt <= '0;
         MemErr_o <= 1'b0;
      end else begin
         wait_cnt <= wait_next;
         case (state)
            IDLE:     if (mem_stall)  state <= MEM_WAIT;
            MEM_WAIT: if (!mem_stall) state <= IDLE;
            default:  state <= IDLE;
         endcase
         if (mem_stall && (wait_next == WAIT_MAX))
            MemErr_o <= 1'b1;
      end
   end

   // ---------------- performance counters ----------------
   sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_count (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (StallF_o),
      .count (StallCount_o)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_count (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (FlushE_o),
      .count (FlushCount_o)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit

module tb_hazard_unit;

   localparam int AW  = 5;
   localparam int CW  = 3;
   localparam int TO  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic [1:0]    rsrc;
   logic          pcsrc, regwm, regww, memreq, memready;

   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_e, flush_w;
   logic [1:0]    fwd_a, fwd_b;
   logic          mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_unit #(
      .REGISTER_ADDRESS_WIDTH(AW),
      .COUNT_WIDTH(CW),
      .MEM_TIMEOUT(TO)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .Rs1D_i       (rs1d),
      .Rs2D_i       (rs2d),
      .Rs1E_i       (rs1e),
      .Rs2E_i       (rs2e),
      .RdE_i        (rde),
      .ResultSrcE_i (rsrc),
      .PCSrcE_i     (pcsrc),
      .RdM_i        (rdm),
      .RegWriteM_i  (regwm),
      .RdW_i        (rdw),
      .RegWriteW_i  (regww),
      .MemReqM_i    (memreq),
      .MemReadyM_i  (memready),
      .StallF_o     (stall_f),
      .StallD_o     (stall_d),
      .StallE_o     (stall_e),
      .StallM_o     (stall_m),
      .FlushD_o     (flush_d),
      .FlushE_o     (flush_e),
      .FlushW_o     (flush_w),
      .ForwardAE_o  (fwd_a),
      .ForwardBE_o  (fwd_b),
      .MemErr_o     (mem_err),
      .StallCount_o (stall_cnt),
      .FlushCount_o (flush_cnt)
   );

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
      logic [1:0] rsrc;
      logic       pcsrc;
      logic [4:0] rdm;
      logic       regwm;
      logic [4:0] rdw;
      logic       regww, memreq, memready;
   } in_t;

   typedef struct {
      in_t         in;
      logic [10:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t         sb[$];
   int          tests = 0;
   int          fails = 0;
   int          m_sc  = 0;
   int          m_fc  = 0;
   logic [10:0] last_exp = '0;
   vec_t        tbl[14];

   function automatic in_t mk(input logic [4:0] a_rs1d, a_rs2d, a_rs1e, a_rs2e, a_rde,
                              input logic [1:0] a_rsrc, input logic a_pc,
                              input logic [4:0] a_rdm, input logic a_rwm,
                              input logic [4:0] a_rdw, input logic a_rww,
                              input logic a_mrq, input logic a_mrdy);
      in_t r;
      r.rs1d = a_rs1d; r.rs2d = a_rs2d; r.rs1e = a_rs1e; r.rs2e = a_rs2e;
      r.rde = a_rde; r.rsrc = a_rsrc; r.pcsrc = a_pc; r.rdm = a_rdm;
      r.regwm = a_rwm; r.rdw = a_rdw; r.regww = a_rww;
      r.memreq = a_mrq; r.memready = a_mrdy;
      return r;
   endfunction

   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
   function automatic logic [10:0] ex(input logic sfd, input logic sem, input logic fd,
                                      input logic fe, input logic fw,
                                      input logic [1:0] fa, input logic [1:0] fb);
      return {sfd, sfd, sem, sem, fd, fe, fw, fa, fb};
   endfunction

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         0:       return {21'b0, stall_f, stall_d, stall_e, stall_m,
                          flush_d, flush_e, flush_w, fwd_a, fwd_b};
         1:       return 32'(stall_cnt);
         2:       return 32'(flush_cnt);
         default: return {31'b0, mem_err};
      endcase
   endfunction

   task automatic apply(input in_t v);
      rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e; rde = v.rde;
      rsrc = v.rsrc; pcsrc = v.pcsrc; rdm = v.rdm; regwm = v.regwm;
      rdw = v.rdw; regww = v.regww; memreq = v.memreq; memready = v.memready;
   endtask

   task automatic push(input int kind, input logic [31:0] exp, input string name);
      sb_t s;
      s.kind = kind; s.exp = exp; s.name = name;
      sb.push_back(s);
   endtask

   task automatic check_sb();
      sb_t         s;
      logic [31:0] a;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         a = actual(s.kind);
         tests++;
         if (a !== s.exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", s.name, a, s.exp);
         end
      end
   endtask

   task automatic drive(input in_t v, input logic [10:0] exp, input string name);
      @(negedge clk);
      apply(v);
      last_exp = exp;
      push(0, {21'b0, exp}, {name, "/ctrl"});
      #1;
      check_sb();
   endtask

   // Advance one edge; the counter model follows the control values the bench
   // itself expected for the cycle that just ended.
   task automatic tick(input logic err, input string name);
      if (last_exp[10] && m_sc < SAT) m_sc++;
      if (last_exp[5]  && m_fc < SAT) m_fc++;
      push(1, 32'(m_sc), {name, "/stall_cnt"});
      push(2, 32'(m_fc), {name, "/flush_cnt"});
      push(3, {31'b0, err}, {name, "/mem_err"});
      @(posedge clk);
      #1;
      check_sb();
   endtask

   task automatic step(input in_t v, input logic [10:0] exp, input logic err,
                       input string name);
      drive(v, exp, name);
      tick(err, name);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
      last_exp = '0;
      m_sc = 0;
      m_fc = 0;
      #1;
      push(1, 32'd0, {name, "/stall_cnt"});
      push(2, 32'd0, {name, "/flush_cnt"});
      push(3, 32'd0, {name, "/mem_err"});
      check_sb();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   in_t         ms_pc, ms, rdy_pc, rdy, lw;
   logic [10:0] e_ms;

   initial begin
      rst_n = 1'b0;
      apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));

      //          rs1d rs2d rs1e rs2e rde rsrc pc rdm rwm rdw rww mrq mrdy
      tbl[0]  = '{mk(0,0,0,0,0, 2'b00,0, 0,0, 0,0, 0,0), ex(0,0,0,0,0,2'b00,2'b00), "idle"};
      tbl[1]  = '{mk(0,0,5,0,0, 2'b00,0, 5,1, 5,1, 0,0), ex(0,0,0,0,0,2'b10,2'b00), "fwd_m_a"};
      tbl[2]  = '{mk(0,0,0,0,0, 2'b00,0, 5,1, 5,1, 0,0), ex(0,0,0,0,0,2'b00,2'b00), "fwd_x0"};
      tbl[3]  = '{mk(0,0,7,7,0, 2'b00,0, 6,1, 7,1, 0,0), ex(0,0,0,0,0,2'b01,2'b01), "fwd_w"};
      tbl[4]  = '{mk(0,0,4,9,0, 2'b00,0, 9,1, 4,1, 0,0), ex(0,0,0,0,0,2'b01,2'b10), "fwd_mix"};
      tbl[5]  = '{mk(0,0,5,5,0, 2'b00,0, 5,0, 0,0, 0,0), ex(0,0,0,0,0,2'b00,2'b00), "fwd_nowr"};
      tbl[6]  = '{mk(0,3,0,0,3, 2'b01,0, 0,0, 0,0, 0,0), ex(1,0,0,1,0,2'b00,2'b00), "load_use"};
      tbl[7]  = '{mk(0,0,0,0,0, 2'b01,0, 0,0, 0,0, 0,0), ex(0,0,0,0,0,2'b00,2'b00), "load_x0"};
      tbl[8]  = '{mk(3,0,0,0,3, 2'b10,0, 0,0, 0,0, 0,0), ex(0,0,0,0,0,2'b00,2'b00), "nonload"};
      tbl[9]  = '{mk(0,0,0,0,0, 2'b00,1, 0,0, 0,0, 0,0), ex(0,0,1,1,0,2'b00,2'b00), "branch"};
      tbl[10] = '{mk(3,0,0,0,3, 2'b01,1, 0,0, 0,0, 0,0), ex(1,0,1,1,0,2'b00,2'b00), "lw_branch"};
      tbl[11] = '{mk(0,0,0,0,0, 2'b00,1, 0,0, 0,0, 1,0), ex(1,1,0,0,1,2'b00,2'b00), "mem_stall"};
      tbl[12] = '{mk(0,0,0,0,0, 2'b00,0, 0,0, 0,0, 1,1), ex(0,0,0,0,0,2'b00,2'b00), "mem_ready"};
      tbl[13] = '{mk(3,0,0,0,3, 2'b01,0, 0,0, 0,0, 1,0), ex(1,1,0,0,1,2'b00,2'b00), "mem_lw"};

      ms_pc  = mk(0,0,0,0,0,2'b00,1,0,0,0,0,1,0);
      ms     = mk(0,0,0,0,0,2'b00,0,0,0,0,0,1,0);
      rdy_pc = mk(0,0,0,0,0,2'b00,1,0,0,0,0,1,1);
      rdy    = mk(0,0,0,0,0,2'b00,0,0,0,0,0,1,1);
      lw     = mk(0,3,0,0,3,2'b01,0,0,0,0,0,0,0);
      e_ms   = ex(1,1,0,0,1,2'b00,2'b00);

      do_reset("reset");

      for (int i = 0; i < 14; i++)
         step(tbl[i].in, tbl[i].exp, 1'b0, tbl[i].name);

      // Load-use then taken branch: counters move by one each
      do_reset("reset_lb");
      step(lw, ex(1,0,0,1,0,2'b00,2'b00), 1'b0, "lu_cnt");
      step(mk(0,0,0,0,0,2'b00,1,0,0,0,0,0,0), ex(0,0,1,1,0,2'b00,2'b00), 1'b0, "br_cnt");

      // Three-cycle memory wait with a pending branch, then a second wait
      do_reset("reset_mw");
      for (int i = 0; i < 3; i++) step(ms_pc, e_ms, 1'b0, "mw_stall");
      step(rdy_pc, ex(0,0,1,1,0,2'b00,2'b00), 1'b0, "mw_ready");
      for (int i = 0; i < 3; i++) step(ms, e_ms, 1'b0, "mw2_stall");
      step(rdy, ex(0,0,0,0,0,2'b00,2'b00), 1'b0, "mw2_ready");

      // Timeout: error after the 4th stalled edge, sticky, async clear
      do_reset("reset_to");
      for (int i = 0; i < 6; i++) step(ms, e_ms, (i >= TO - 1), $sformatf("to_%0d", i + 1));
      step(rdy, ex(0,0,0,0,0,2'b00,2'b00), 1'b1, "to_sticky");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      push(3, 32'd0, "to_async_clr/mem_err");
      check_sb();
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a wait: the count restarts from one
      do_reset("reset_mid");
      m_sc = 0; m_fc = 0;
      step(ms, e_ms, 1'b0, "mid_a");
      step(ms, e_ms, 1'b0, "mid_b");
      drive(ms, e_ms, "mid_c");
      rst_n = 1'b0;
      m_sc = 0; m_fc = 0;
      #1;
      push(0, {21'b0, e_ms}, "mid_rst/ctrl");
      push(1, 32'd0, "mid_rst/stall_cnt");
      push(3, 32'd0, "mid_rst/mem_err");
      check_sb();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick((i == 3), $sformatf("mid_re_%0d", i + 1));

      // Saturation: ten load-use cycles on a 3-bit counter
      do_reset("reset_sat");
      for (int i = 0; i < 10; i++) step(lw, ex(1,0,0,1,0,2'b00,2'b00), 1'b0, $sformatf("sat_%0d", i));
      push(1, 32'd7, "sat_final/stall_cnt");
      push(2, 32'd7, "sat_final/flush_cnt");
      check_sb();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
